column_reader: RTL and testbench
================================

# column_reader

Scan-out side of the column buffer. Software and the Avalon column writer fill one bank of per-column wall descriptors while this block reads the other bank in step with the VGA counters. For each pixel it fetches the column descriptor and resolves ceiling, wall or floor, then reads the texel and emits final RGB with a fixed latency. It sits between `vga_counters`, the column/texture RAMs and the VGA colour pins, and owns the bank-swap handshake with the writer.

## Interface
- `CEIL_COLOR`, 24'h404040, RGB shown above the wall
- `FLOOR_COLOR`, 24'h202020, RGB shown below the wall
- `clk`  in  1  system clock (50 MHz)
- `reset`  in  1  asynchronous, active-high
- `hcount`  in  11  from `vga_counters`; pixel x = `hcount[10:1]`
- `vcount`  in  10  from `vga_counters`
- `swap_req`  in  1  level; writer has finished filling the back bank
- `swap_ack`  out  1  one-cycle pulse when the swap is taken
- `col_bank`  out  1  bank currently displayed
- `col_addr`  out  11  `{col_bank, x}`, registered
- `col_rdata`  in  32  column word, 1-clock synchronous RAM read
- `tex_addr`  out  15  `{tex_num, tex_row, tex_col}`, registered
- `tex_rdata`  in  8  RGB332 texel, 1-clock synchronous RAM read
- `pix_r`, `pix_g`, `pix_b`  out  8 each  registered colour

## Operation
- Column word fields:
  - [31:22] `height` (10b)
  - [21:16] `tex_col` (6b)
  - [15:13] `tex_num` (3b)
  - [12] `side`
  - [11:0] `tex_step`, unsigned Q6.6 (software writes round(4096/height), saturated at 0xFFF)
- Lookahead position: la_h = `hcount`+6.
  - If la_h ≥ 1600, wrap it to la_h−1600 and set la_v = `vcount`+1. If that makes la_v = 525, la_v = 0.
  - la_x = la_h[10:1], la_y = la_v.
  - The lookahead position is active when la_x < 640 and la_y < 480.
- Wall extent: top = 240 − (height>>1), 12-bit signed; bottom = top + height, exclusive.
- Region:
  - ceiling when y < top
  - wall when top ≤ y < bottom
  - floor when y ≥ bottom
  - height 0 gives no wall: ceiling for y < 240, floor otherwise.
- tex_row = (((y − top) × tex_step) >> 6)[5:0]. The product is 23 bits; the row wraps modulo 64.
- Texel expansion:
  - R = {t[7:5], t[7:5], t[7:6]}
  - G = {t[4:2], t[4:2], t[4:3]}
  - B = {t[1:0] ×4}
- Inactive lookahead position: RGB = 0.
- Swap handshake:
  - An `armed` flag is set while `swap_req` is observed low.
  - At the cycle with `hcount`==0 and `vcount`==480, if `armed` and `swap_req` are both high, then on the next cycle `col_bank` toggles, `swap_ack` pulses and `armed` clears.
  - Holding `swap_req` high therefore produces exactly one swap.
- Reset (asynchronous, any time, including mid-line): `col_addr`=0, `tex_addr`=0, RGB=0, `col_bank`=0, `swap_ack`=0, `armed`=0. The pipeline is flushed to the inactive state.

## Timing
- Latency is 6 clocks: the `pix_*` outputs at cycle t belong to the pixel at (`hcount`(t), `vcount`(t)).
- t: lookahead computed; `col_addr` registered.
- t+2: `col_rdata` valid; decode, region and offset are registered.
- t+3: multiply done; `tex_addr` registered.
- t+5: `tex_rdata` valid.
- t+6: RGB registered.
- The pipeline advances every clock. Each pixel is computed twice; both results are identical.
- Bank switch visibility: `col_addr` uses the new bank starting from the cycle after the swap, which falls in vertical blank.
- Back-to-back requests: writer deasserting `swap_req` for ≥ 1 clock after `swap_ack` re-arms the block.

## Configuration
- `COLUMN_READER_SHADE_EN`
  - Defined: when `side`=1, each wall channel is shifted right by 1. Ceiling and floor are unaffected.
  - Undefined: `side` is ignored and there is no shading logic.

## Structure
- `column_pkg`:
  - packed struct `column_word_t` for the field layout
  - constants SCREEN_W=640, SCREEN_H=480, HTOTAL=1600, VTOTAL=525, HORIZON=240, LATENCY=6
- One sub-module, `scan_lookahead`: wrap-aware lookahead position and active flag.

## Test plan
- Assert `reset` mid-line at `hcount`=700, `vcount`=100 → all outputs 0 and `col_bank`=0 immediately. Correct pixels appear from 6 clocks after release.
- Column 10 word: height=240, tex_col=5, tex_num=2, tex_step=0x011. Pixel y=240 → `tex_addr`={3'd2, 6'd31, 6'd5}. `tex_rdata`=0xE0 → pix=(FF,00,00) at x=10.
- Column 20, height=0 → y=100 gives `CEIL_COLOR`; y=300 gives `FLOOR_COLOR`.
- `hcount`=1594, `vcount`=9 → `col_addr`={bank, 0}. Output at `hcount`=0, `vcount`=10 is column 0 of row 10.
- `swap_req` raised at `vcount`=200 and held:
  - one `swap_ack` pulse on the cycle after (`hcount`=0, `vcount`=480), `col_bank` 0→1
  - no swap the following frame
  - drop for 1 clock and re-raise → swap back to 0.
- side=1, texel 0xFF → pix=(7F,7F,7F) with `COLUMN_READER_SHADE_EN`, (FF,FF,FF) without.

Source files
------------

// File: rtl/column_pkg.sv
// Shared field layout, screen timing constants and fill colours for column_reader.
package column_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int HTOTAL   = 1600;
  localparam int VTOTAL   = 525;
  localparam int HORIZON  = 240;
  localparam int LATENCY  = 6;

  localparam logic [23:0] CEIL_COLOR  = 24'h404040;
  localparam logic [23:0] FLOOR_COLOR = 24'h202020;

  typedef struct packed {
    logic [9:0]  height;
    logic [5:0]  tex_col;
    logic [2:0]  tex_num;
    logic        side;
    logic [11:0] tex_step;
  } column_word_t;

  typedef enum logic [1:0] {
    REGION_CEIL,
    REGION_WALL,
    REGION_FLOOR
  } region_t;

  // RGB332 to RGB888 by bit replication so full-scale texels map to 0xFF.
  function automatic logic [23:0] expand_rgb332(input logic [7:0] t);
    return {t[7:5], t[7:5], t[7:6],
            t[4:2], t[4:2], t[4:3],
            {4{t[1:0]}}};
  endfunction

endpackage

// File: rtl/scan_lookahead.sv
// Position of the pixel LATENCY clocks ahead of the VGA counters, with line/frame wrap.
module scan_lookahead
  import column_pkg::*;
(
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [9:0]  la_x,
  output logic [9:0]  la_y,
  output logic        active
);

  logic [11:0] h_ahead;
  logic [11:0] h_wrapped;
  logic [10:0] v_next;
  logic [9:0]  v_ahead;
  logic        unused_bits;

  always_comb begin
    h_ahead   = {1'b0, hcount} + 12'(LATENCY);
    h_wrapped = h_ahead;
    v_next    = {1'b0, vcount} + 11'd1;
    v_ahead   = vcount;
    if (h_ahead >= 12'(HTOTAL)) begin
      h_wrapped = h_ahead - 12'(HTOTAL);
      v_ahead   = (v_next == 11'(VTOTAL)) ? 10'd0 : v_next[9:0];
    end
  end

  assign la_x   = h_wrapped[10:1];
  assign la_y   = v_ahead;
  assign active = (la_x < 10'(SCREEN_W)) && (la_y < 10'(SCREEN_H));

  assign unused_bits = ^{h_wrapped[11], h_wrapped[0], v_next[10]};

endmodule

// File: rtl/column_reader.sv
// Column buffer scan-out: column fetch, region/texel resolve, RGB out 6 clocks later.
// Optional wall shading for side=1 columns is enabled by COLUMN_READER_SHADE_EN.
module column_reader
  import column_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        col_bank,
  output logic [10:0] col_addr,
  input  logic [31:0] col_rdata,
  output logic [14:0] tex_addr,
  input  logic [7:0]  tex_rdata,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b
);

  logic armed;
  logic swap_point;

  assign swap_point = (hcount == 11'd0) && (vcount == 10'(SCREEN_H));

  // A held request swaps once; it must be seen low again before the next swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_bank <= 1'b0;
      swap_ack <= 1'b0;
      armed    <= 1'b0;
    end else if (swap_point && armed && swap_req) begin
      col_bank <= ~col_bank;
      swap_ack <= 1'b1;
      armed    <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (!swap_req) armed <= 1'b1;
    end
  end

  logic [9:0] la_x;
  logic [9:0] la_y;
  logic       la_active;

  scan_lookahead u_lookahead (
    .hcount (hcount),
    .vcount (vcount),
    .la_x   (la_x),
    .la_y   (la_y),
    .active (la_active)
  );

  logic [9:0] y_s1, y_s2;
  logic       active_s1, active_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_addr  <= 11'd0;
      y_s1      <= 10'd0;
      y_s2      <= 10'd0;
      active_s1 <= 1'b0;
      active_s2 <= 1'b0;
    end else begin
      col_addr  <= {col_bank, la_x};
      y_s1      <= la_y;
      active_s1 <= la_active;
      y_s2      <= y_s1;
      active_s2 <= active_s1;
    end
  end

  column_word_t       word;
  logic signed [11:0] wall_top;
  logic signed [11:0] wall_bottom;
  logic signed [11:0] y_signed;
  logic [11:0]        offset_d;
  region_t            region_d;

  assign word = column_word_t'(col_rdata);

  // Height 0 collapses the wall to an empty span at the horizon.
  always_comb begin
    wall_top    = $signed(12'(HORIZON)) - $signed({3'b000, word.height[9:1]});
    wall_bottom = wall_top + $signed({2'b00, word.height});
    y_signed    = $signed({2'b00, y_s2});
    offset_d    = y_signed - wall_top;
    region_d    = REGION_WALL;
    if (y_signed < wall_top)
      region_d = REGION_CEIL;
    else if (y_signed >= wall_bottom)
      region_d = REGION_FLOOR;
  end

  region_t     region_s3, region_s4, region_s5;
  logic [10:0] offset_s3;
  logic [11:0] step_s3;
  logic [5:0]  tex_col_s3;
  logic [2:0]  tex_num_s3;
  logic        active_s3, active_s4, active_s5;
  logic [22:0] product;
  logic        unused_bits;

  assign product     = {12'd0, offset_s3} * {11'd0, step_s3};
  assign unused_bits = ^{offset_d[11], product[22:12], product[5:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      region_s3  <= REGION_CEIL;
      offset_s3  <= 11'd0;
      step_s3    <= 12'd0;
      tex_col_s3 <= 6'd0;
      tex_num_s3 <= 3'd0;
      active_s3  <= 1'b0;
      tex_addr   <= 15'd0;
      region_s4  <= REGION_CEIL;
      active_s4  <= 1'b0;
      region_s5  <= REGION_CEIL;
      active_s5  <= 1'b0;
    end else begin
      region_s3  <= region_d;
      offset_s3  <= offset_d[10:0];
      step_s3    <= word.tex_step;
      tex_col_s3 <= word.tex_col;
      tex_num_s3 <= word.tex_num;
      active_s3  <= active_s2;
      tex_addr   <= {tex_num_s3, product[11:6], tex_col_s3};
      region_s4  <= region_s3;
      active_s4  <= active_s3;
      region_s5  <= region_s4;
      active_s5  <= active_s4;
    end
  end

`ifdef COLUMN_READER_SHADE_EN
  logic side_s3, side_s4, side_s5;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      side_s3 <= 1'b0;
      side_s4 <= 1'b0;
      side_s5 <= 1'b0;
    end else begin
      side_s3 <= word.side;
      side_s4 <= side_s3;
      side_s5 <= side_s4;
    end
  end
`else
  logic unused_side;
  assign unused_side = word.side;
`endif

  logic [23:0] wall_rgb;
  logic [23:0] pix_d;

  always_comb begin
    wall_rgb = expand_rgb332(tex_rdata);
`ifdef COLUMN_READER_SHADE_EN
    if (side_s5)
      wall_rgb = {1'b0, wall_rgb[23:17], 1'b0, wall_rgb[15:9], 1'b0, wall_rgb[7:1]};
`endif
    pix_d = 24'h000000;
    if (active_s5) begin
      case (region_s5)
        REGION_CEIL: pix_d = CEIL_COLOR;
        REGION_WALL: pix_d = wall_rgb;
        default:     pix_d = FLOOR_COLOR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_r <= 8'h00;
      pix_g <= 8'h00;
      pix_b <= 8'h00;
    end else begin
      pix_r <= pix_d[23:16];
      pix_g <= pix_d[15:8];
      pix_b <= pix_d[7:0];
    end
  end

endmodule

// File: tb/tb_column_reader.sv
// Directed bench for column_reader with behavioural column/texture RAMs.
module tb_column_reader;

  logic        clk;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        swap_req;
  logic        swap_ack;
  logic        col_bank;
  logic [10:0] col_addr;
  logic [31:0] col_rdata;
  logic [14:0] tex_addr;
  logic [7:0]  tex_rdata;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [23:0] pix;

  localparam logic [23:0] CEIL  = 24'h404040;
  localparam logic [23:0] FLOOR = 24'h202020;
`ifdef COLUMN_READER_SHADE_EN
  localparam logic [23:0] SHADE_EXP = 24'h7F7F7F;
`else
  localparam logic [23:0] SHADE_EXP = 24'hFFFFFF;
`endif

  int assert_count;
  int fail_count;
  int acks, ack_h, ack_v;

  logic [31:0] col_mem [0:2047];
  logic [7:0]  tex_mem [0:32767];

  column_reader dut (
    .clk       (clk),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .col_bank  (col_bank),
    .col_addr  (col_addr),
    .col_rdata (col_rdata),
    .tex_addr  (tex_addr),
    .tex_rdata (tex_rdata),
    .pix_r     (pix_r),
    .pix_g     (pix_g),
    .pix_b     (pix_b)
  );

  assign pix = {pix_r, pix_g, pix_b};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) begin
    col_rdata <= col_mem[col_addr];
    tex_rdata <= tex_mem[tex_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (hcount == 11'd1599) begin
        hcount = 11'd0;
        vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount = hcount + 11'd1;
      end
    end
  endtask

  task automatic setCounters(input int h, input int v);
    hcount = 11'(h);
    vcount = 10'(v);
  endtask

  task automatic gotoPixel(input int h, input int v);
    setCounters(h - 8, v);
    applyStimulus(8);
  endtask

  task automatic runSwapWindow(output int n_ack, output int at_h, output int at_v);
    n_ack = 0;
    at_h  = -1;
    at_v  = -1;
    setCounters(1590, 479);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1);
      if (swap_ack) begin
        n_ack++;
        at_h = int'(hcount);
        at_v = int'(vcount);
      end
    end
  endtask

  function automatic logic [31:0] makeWord(input logic [9:0] height, input logic [5:0] tex_col,
                                           input logic [2:0] tex_num, input logic side,
                                           input logic [11:0] step);
    return {height, tex_col, tex_num, side, step};
  endfunction

  initial begin
    assert_count = 0;
    fail_count   = 0;
    reset    = 1'b1;
    swap_req = 1'b0;
    setCounters(0, 0);
    for (int i = 0; i < 2048; i++) col_mem[i] = 32'd0;
    for (int i = 0; i < 32768; i++) tex_mem[i] = 8'd0;

    col_mem[10] = makeWord(10'd240, 6'd5, 3'd2, 1'b0, 12'h011);
    col_mem[0]  = makeWord(10'd500, 6'd0, 3'd1, 1'b0, 12'h040);
    col_mem[30] = makeWord(10'd240, 6'd7, 3'd3, 1'b1, 12'h040);
    tex_mem[15'h27C5] = 8'hE0;
    tex_mem[12229]    = 8'h1C;
    tex_mem[8197]     = 8'h03;
    tex_mem[5376]     = 8'hFF;
    tex_mem[15879]    = 8'hFF;

    applyStimulus(3);
    checkOutput("reset_col_addr", 32'(col_addr), 32'd0);
    checkOutput("reset_tex_addr", 32'(tex_addr), 32'd0);
    checkOutput("reset_pix", 32'(pix), 32'd0);
    checkOutput("reset_bank", 32'(col_bank), 32'd0);
    #2 reset = 1'b0;

    gotoPixel(19, 240);
    checkOutput("tex_addr_wall", 32'(tex_addr), 32'h27C5);
    applyStimulus(1);
    checkOutput("wall_red_even", 32'(pix), 32'hFF0000);
    applyStimulus(1);
    checkOutput("wall_red_odd", 32'(pix), 32'hFF0000);
    gotoPixel(20, 120);
    checkOutput("wall_top_row", 32'(pix), 32'h0000FF);
    gotoPixel(20, 119);
    checkOutput("ceil_above_top", 32'(pix), 32'(CEIL));
    gotoPixel(20, 359);
    checkOutput("wall_last_row", 32'(pix), 32'h00FF00);
    gotoPixel(20, 360);
    checkOutput("floor_at_bottom", 32'(pix), 32'(FLOOR));

    gotoPixel(40, 100);
    checkOutput("h0_ceil_100", 32'(pix), 32'(CEIL));
    gotoPixel(40, 239);
    checkOutput("h0_ceil_239", 32'(pix), 32'(CEIL));
    gotoPixel(40, 240);
    checkOutput("h0_floor_240", 32'(pix), 32'(FLOOR));
    gotoPixel(40, 300);
    checkOutput("h0_floor_300", 32'(pix), 32'(FLOOR));

    gotoPixel(1279, 100);
    checkOutput("last_active_x", 32'(pix), 32'(CEIL));
    applyStimulus(1);
    checkOutput("h_blank", 32'(pix), 32'd0);
    gotoPixel(100, 479);
    checkOutput("last_active_row", 32'(pix), 32'(FLOOR));
    gotoPixel(100, 480);
    checkOutput("v_blank", 32'(pix), 32'd0);

    setCounters(1590, 9);
    applyStimulus(4);
    checkOutput("col_addr_pre_wrap", 32'(col_addr), 32'd799);
    applyStimulus(1);
    checkOutput("col_addr_wrap", 32'(col_addr), 32'd0);
    applyStimulus(5);
    checkOutput("wrap_pixel", 32'(pix), 32'hFFFFFF);

    gotoPixel(60, 240);
    checkOutput("side_wall", 32'(pix), 32'(SHADE_EXP));
    gotoPixel(60, 100);
    checkOutput("side_ceiling", 32'(pix), 32'(CEIL));

    setCounters(0, 200);
    applyStimulus(2);
    swap_req = 1'b1;
    runSwapWindow(acks, ack_h, ack_v);
    checkOutput("swap1_count", 32'(acks), 32'd1);
    checkOutput("swap1_hcount", 32'(ack_h), 32'd1);
    checkOutput("swap1_vcount", 32'(ack_v), 32'd480);
    checkOutput("swap1_bank", 32'(col_bank), 32'd1);
    runSwapWindow(acks, ack_h, ack_v);
    checkOutput("held_no_swap", 32'(acks), 32'd0);
    checkOutput("held_bank", 32'(col_bank), 32'd1);
    swap_req = 1'b0;
    applyStimulus(1);
    swap_req = 1'b1;
    runSwapWindow(acks, ack_h, ack_v);
    checkOutput("swap2_count", 32'(acks), 32'd1);
    checkOutput("swap2_bank", 32'(col_bank), 32'd0);
    swap_req = 1'b0;
    applyStimulus(1);
    swap_req = 1'b1;
    runSwapWindow(acks, ack_h, ack_v);
    checkOutput("swap3_bank", 32'(col_bank), 32'd1);
    gotoPixel(101, 10);
    checkOutput("bank1_col_addr", 32'(col_addr), 32'd1077);
    gotoPixel(20, 240);
    checkOutput("bank1_pixel", 32'(pix), 32'(FLOOR));

    setCounters(690, 100);
    applyStimulus(10);
    checkOutput("pre_reset_pix", 32'(pix), 32'(CEIL));
    #2 reset = 1'b1;
    #1;
    checkOutput("midline_reset_pix", 32'(pix), 32'd0);
    checkOutput("midline_reset_bank", 32'(col_bank), 32'd0);
    checkOutput("midline_reset_col_addr", 32'(col_addr), 32'd0);
    checkOutput("midline_reset_tex_addr", 32'(tex_addr), 32'd0);
    checkOutput("midline_reset_ack", 32'(swap_ack), 32'd0);
    applyStimulus(2);
    #2 reset = 1'b0;
    applyStimulus(5);
    checkOutput("flush_pix", 32'(pix), 32'd0);
    applyStimulus(1);
    checkOutput("post_reset_pix", 32'(pix), 32'(CEIL));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
